fifo_ser_tx: RTL and testbench



---
 rtl/fifo_ser_tx_if.sv | 24 ++
 rtl/fifo_ser_tx.sv | 143 ++++++++++++++
 tb/tb_fifo_ser_tx.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ser_tx_if.sv
// FIFO read-port bundle between the byte FIFO and its serial transmitter.
//   fifo_empty : FIFO has no readable data (FIFO -> consumer)
//   fifo_d     : read data, valid the cycle after a pop (FIFO -> consumer)
//   fifo_rd    : single-cycle pop strobe (consumer -> FIFO)
// The consumer side uses the master modport; the FIFO side uses slave.
interface fifo_ser_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_d;
    logic              fifo_rd;

    modport master (
        input  fifo_empty,
        input  fifo_d,
        output fifo_rd
    );

    modport slave (
        output fifo_empty,
        output fifo_d,
        input  fifo_rd
    );
endinterface

// File: rtl/fifo_ser_tx.sv
// Serial transmitter draining the byte FIFO in the out_clk domain.
// Each popped byte goes out as 1 start bit (0), DATA_W data bits LSB first
// and 1 stop bit (1), every bit held for CLKS_PER_BIT clocks.
//   out_clk  : block clock, rising edge
//   reset    : asynchronous, active-low
//   enable   : 1 = new frames may be started
//   fifo     : FIFO read port (master side: fifo_empty, fifo_d in; fifo_rd out)
//   tx       : serial line, idle high (registered)
//   busy     : frame in progress, any state but IDLE (registered)
//   byte_cnt : frames fully sent, wraps at 16 bits
module fifo_ser_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic          out_clk,
    input  logic          reset,
    input  logic          enable,
    fifo_ser_tx_if.master fifo,
    output logic          tx,
    output logic          busy,
    output logic [15:0]   byte_cnt
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_e;

    state_e              state_q,    state_d;
    logic [15:0]         baud_q,     baud_d;
    logic [BIT_W-1:0]    bit_q,      bit_d;
    logic [DATA_W-1:0]   shift_q,    shift_d;
    logic [15:0]         byte_cnt_q, byte_cnt_d;
    logic                tx_q,       tx_d;
    logic                fifo_rd_q,  fifo_rd_d;
    logic                busy_q,     busy_d;

    logic                baud_last;
    logic                bit_last;

    assign baud_last = (baud_q == 16'(CLKS_PER_BIT - 1));
    assign bit_last  = (bit_q == BIT_W'(DATA_W - 1));

    always_ff @(posedge out_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            tx_q       <= 1'b1;
            fifo_rd_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            tx_q       <= tx_d;
            fifo_rd_q  <= fifo_rd_d;
            busy_q     <= busy_d;
        end
    end

    // An IDLE cycle with the pop strobe already high has committed to the
    // pop, so it always proceeds to FETCH.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (fifo_rd_q) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                shift_d = fifo.fifo_d;
                baud_d  = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_last) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d     = '0;
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    state_d    = IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they belong to. The pop strobe is raised on the edge
    // that enters (or stays in) IDLE, making it high during that IDLE cycle.
    always_comb begin
        fifo_rd_d = (state_d == IDLE) && enable && !fifo.fifo_empty;
        busy_d    = (state_d != IDLE);
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    assign fifo.fifo_rd = fifo_rd_q;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign byte_cnt     = byte_cnt_q;

endmodule

// File: tb/tb_fifo_ser_tx.sv
// Bench for fifo_ser_tx: a FIFO read-port model feeds bytes, popped bytes
// are queued as expected frames, and a line monitor rebuilds every frame
// from tx and compares it against the queue.
module tb_fifo_ser_tx;

    localparam int CPB       = 4;
    localparam int DW        = 8;
    localparam int FRAME_CYC = (DW + 2) * CPB;
    localparam logic [63:0] BUSY_MASK = (64'd1 << FRAME_CYC) - 64'd1;

    logic        out_clk;
    logic        reset;
    logic        enable;
    logic        tx;
    logic        busy;
    logic [15:0] byte_cnt;

    fifo_ser_tx_if #(.DATA_W(DW)) fifo_if ();

    fifo_ser_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (DW)
    ) dut (
        .out_clk (out_clk),
        .reset   (reset),
        .enable  (enable),
        .fifo    (fifo_if),
        .tx      (tx),
        .busy    (busy),
        .byte_cnt(byte_cnt)
    );

    initial out_clk = 1'b0;
    always #5 out_clk = ~out_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] frame_bits(input logic [7:0] b);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            int k;
            k = i / CPB;
            if (k == 0)           v[i] = 1'b0;
            else if (k == DW + 1) v[i] = 1'b1;
            else                  v[i] = b[k-1];
        end
        return v;
    endfunction

    // FIFO contents, scoreboard and monitor state
    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  pop_b;
    logic        rd_pend      = 1'b0;
    int          rd_count     = 0;
    int          since_rd     = 1000;
    logic        in_frame     = 1'b0;
    logic        post_pending = 1'b0;
    int          nsamp        = 0;
    logic [63:0] obs_tx       = '0;
    logic [63:0] obs_busy     = '0;
    int          frames_done  = 0;
    int          gap          = 0;
    int          last_gap     = 0;
    logic [15:0] model_cnt    = '0;

    always @(negedge out_clk) begin
        if (!reset) begin
            rd_pend        = 1'b0;
            exp_q.delete();
            in_frame       = 1'b0;
            post_pending   = 1'b0;
            model_cnt      = '0;
            gap            = 0;
            since_rd       = 1000;
            fifo_if.fifo_d = 8'($urandom);
        end else begin
            // data is present only in the cycle after the pop strobe
            if (rd_pend) begin
                rd_pend = 1'b0;
                if (fifo_q.size() > 0) begin
                    pop_b          = fifo_q.pop_front();
                    fifo_if.fifo_d = pop_b;
                    exp_q.push_back(pop_b);
                end
            end else begin
                fifo_if.fifo_d = 8'($urandom);
            end
            if (since_rd < 1000) since_rd++;
            if (fifo_if.fifo_rd) begin
                rd_count++;
                check_eq("rd_while_empty", fifo_if.fifo_empty, 1'b0);
                rd_pend  = 1'b1;
                since_rd = 0;
            end

            if (in_frame) begin
                obs_tx[nsamp]   = tx;
                obs_busy[nsamp] = busy;
                nsamp++;
                if (nsamp == FRAME_CYC) begin
                    in_frame = 1'b0;
                    post_pending = 1'b1;
                    check_eq("sb_has_entry", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        pop_b = exp_q.pop_front();
                        check_eq("frame_tx", obs_tx, frame_bits(pop_b));
                    end
                    check_eq("frame_busy", obs_busy, BUSY_MASK);
                    model_cnt = model_cnt + 16'd1;
                    frames_done++;
                end
            end else if (post_pending) begin
                post_pending = 1'b0;
                check_eq("post_idle", {tx, busy}, 2'b10);
                check_eq("byte_cnt", byte_cnt, model_cnt);
                gap = tx ? 1 : 0;
            end else if (!tx) begin
                in_frame    = 1'b1;
                last_gap    = gap;
                check_eq("latency", since_rd, 2);
                obs_tx      = '0;
                obs_busy    = '0;
                obs_tx[0]   = tx;
                obs_busy[0] = busy;
                nsamp       = 1;
            end else begin
                gap++;
            end
        end
        fifo_if.fifo_empty = (fifo_q.size() == 0);
    end

    task automatic wait_frames(input string tag, input int target);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge out_clk);
            #1;
            if (frames_done >= target && !in_frame && !post_pending) ok = 1'b1;
        end
        check_eq(tag, ok, 1'b1);
    endtask

    // Returns just after the monitor recorded sample idx of the current frame.
    task automatic wait_sample(input string tag, input int idx);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge out_clk);
            #1;
            if (in_frame && nsamp == idx + 1) ok = 1'b1;
        end
        check_eq(tag, ok, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int  rd0;
    int  f0;
    bit  activity;

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'hA5);

        // reset holds everything quiet even with data available
        repeat (3) @(negedge out_clk);
        #1;
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_rd", fifo_if.fifo_rd, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_cnt", byte_cnt, 16'h0000);
        #1 reset = 1'b1;
        @(posedge out_clk);
        #1;
        check_eq("first_rd", fifo_if.fifo_rd, 1'b1);

        // reset during data bit 5 of 0x5A
        wait_sample("wait_bit5", CPB * 6);
        reset = 1'b0;
        #1;
        check_eq("midrst_tx", tx, 1'b1);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_cnt", byte_cnt, model_cnt);
        repeat (3) @(negedge out_clk);
        #2 reset = 1'b1;

        // next byte 0xA5 goes out whole
        rd0 = rd_count;
        f0  = frames_done;
        wait_frames("wait_a5", f0 + 1);
        check_eq("a5_rd_pulses", rd_count - rd0, 1);
        check_eq("a5_cnt", byte_cnt, 16'd1);

        // back-to-back 0x00, 0xFF
        rd0 = rd_count;
        f0  = frames_done;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        wait_frames("wait_b2b", f0 + 2);
        check_eq("b2b_rd_pulses", rd_count - rd0, 2);
        check_eq("b2b_gap", last_gap, 2);
        check_eq("b2b_cnt", byte_cnt, 16'd3);

        // empty FIFO: nothing happens
        rd0 = rd_count;
        activity = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge out_clk);
            #1;
            if (!tx || busy) activity = 1'b1;
        end
        check_eq("empty_activity", activity, 1'b0);
        check_eq("empty_rd", rd_count - rd0, 0);

        // enable dropped during data bit 3 of 0x3C
        rd0 = rd_count;
        f0  = frames_done;
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h11);
        wait_sample("wait_bit3", CPB * 4);
        enable = 1'b0;
        wait_frames("wait_3c", f0 + 1);
        repeat (20) @(negedge out_clk);
        #1;
        check_eq("en_rd_pulses", rd_count - rd0, 1);
        check_eq("en_frames", frames_done - f0, 1);
        check_eq("en_fifo_left", fifo_q.size(), 1);
        check_eq("en_cnt", byte_cnt, 16'd4);
        enable = 1'b1;
        wait_frames("wait_11", f0 + 2);
        check_eq("en_cnt2", byte_cnt, 16'd5);

        // byte_cnt wrap
        @(negedge out_clk);
        force dut.byte_cnt_q = 16'hFFFF;
        @(posedge out_clk);
        #1 release dut.byte_cnt_q;
        model_cnt = 16'hFFFF;
        check_eq("preload", byte_cnt, 16'hFFFF);
        f0 = frames_done;
        fifo_q.push_back(8'h96);
        wait_frames("wait_96", f0 + 1);
        check_eq("wrap_cnt", byte_cnt, 16'h0000);

        repeat (4) @(negedge out_clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
